// File: rtl/rx_frame_justify.sv
// UART receive frame assembler: shifts in LSB-first bits, right-justifies each word and queues {data, perr, ferr}.
// Optional build macro RJ_PARITY_CHECK_EN enables parity checking and storage of the perr bit.
module rx_frame_justify #(
  parameter int MAX_BITS   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                bit_stb,
  input  logic                bit_in,
  input  logic [3:0]          word_len,
  input  logic                pen,
  input  logic                ohel,
  input  logic                two_stop,
  output logic [MAX_BITS-1:0] dout,
  output logic                perr,
  output logic                ferr,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic                busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
`ifdef RJ_PARITY_CHECK_EN
  localparam int EW = MAX_BITS + 2;
`else
  localparam int EW = MAX_BITS + 1;
`endif

  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP1, STOP2, PUSH} state_t;

  state_t              state;
  logic [MAX_BITS-1:0] sr;
  logic [3:0]          cnt, wl_r, wl_eff;
  logic                pen_r, two_r, ferr_acc;
  logic                perr_bit;

  assign wl_eff = (word_len < 4'd5 || word_len > 4'(MAX_BITS)) ? 4'(MAX_BITS) : word_len;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      wl_r     <= 4'(MAX_BITS);
      pen_r    <= 1'b0;
      two_r    <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (start) begin
      // start overrides any state; a frame in PUSH still lands in the FIFO this edge
      state    <= DATA;
      sr       <= '0;
      cnt      <= '0;
      wl_r     <= wl_eff;
      pen_r    <= pen;
      two_r    <= two_stop;
      ferr_acc <= 1'b0;
    end else begin
      case (state)
        DATA: if (bit_stb) begin
          sr  <= {bit_in, sr[MAX_BITS-1:1]};
          cnt <= cnt + 4'd1;
          if (cnt + 4'd1 == wl_r) state <= pen_r ? PAR : STOP1;
        end
        PAR: if (bit_stb) state <= STOP1;
        STOP1: if (bit_stb) begin
          ferr_acc <= ferr_acc | ~bit_in;
          state    <= two_r ? STOP2 : PUSH;
        end
        STOP2: if (bit_stb) begin
          ferr_acc <= ferr_acc | ~bit_in;
          state    <= PUSH;
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RJ_PARITY_CHECK_EN
  logic par_acc, ohel_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc <= 1'b0;
      ohel_r  <= 1'b0;
    end else if (start) begin
      par_acc <= 1'b0;
      ohel_r  <= ohel;
    end else if (bit_stb && (state == DATA || state == PAR)) begin
      par_acc <= par_acc ^ bit_in;
    end
  end
  assign perr_bit = pen_r & (par_acc ^ ohel_r);
`else
  logic unused_ohel;
  assign unused_ohel = ohel;
  assign perr_bit    = 1'b0;
`endif

  // FIFO
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [EW-1:0]       entry, head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [NW-1:0]       count;
  logic [MAX_BITS-1:0] data_rj;
  logic                push, pop, full, do_push, drop;

  assign data_rj = sr >> (4'(MAX_BITS) - wl_r);
`ifdef RJ_PARITY_CHECK_EN
  assign entry = {data_rj, perr_bit, ferr_acc};
`else
  assign entry = {data_rj, ferr_acc};
`endif

  assign dout_valid = (count != '0);
  assign full       = (count == NW'(FIFO_DEPTH));
  assign push       = (state == PUSH);
  assign pop        = dout_valid && dout_ready;
  assign do_push    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign head       = mem[rd_ptr];

  assign dout = dout_valid ? head[EW-1 -: MAX_BITS] : '0;
  assign ferr = dout_valid & head[0];
`ifdef RJ_PARITY_CHECK_EN
  assign perr = dout_valid & head[1];
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rx_frame_justify.sv
// Scoreboard bench for rx_frame_justify: expected words queued per frame, compared as the host pops them.
module tb_rx_frame_justify;
  logic       clk = 1'b0;
  logic       reset, start, bit_stb, bit_in, pen, ohel, two_stop, dout_ready, ovf_clr;
  logic [3:0] word_len;
  logic [7:0] dout;
  logic       perr, ferr, dout_valid, ovf, busy;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  rx_frame_justify #(.MAX_BITS(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_stb(bit_stb), .bit_in(bit_in),
    .word_len(word_len), .pen(pen), .ohel(ohel), .two_stop(two_stop),
    .dout(dout), .perr(perr), .ferr(ferr), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pop monitor: a word leaves the FIFO at the posedge following this negedge
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {22'd0, dout, perr, ferr}, 32'h3ff);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e[9:2]));
        chk("perr", 32'(perr), 32'(e[1]));
        chk("ferr", 32'(ferr), 32'(e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    bit_stb = 1'b1; bit_in = b;
    tick();
    bit_stb = 1'b0; bit_in = 1'b0;
  endtask

  task automatic frame_start(input int wl, input bit p_en, input bit odd, input bit two);
    word_len = 4'(wl); pen = p_en; ohel = odd; two_stop = two;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int wl, input bit p_en, input bit odd,
                            input bit two, input bit pbit, input bit s1, input bit s2,
                            input bit expect_out);
    int ewl;
    logic [7:0] md;
    logic e_perr;
    ewl = (wl < 5 || wl > 8) ? 8 : wl;
    md  = d & 8'((1 << ewl) - 1);
    frame_start(wl, p_en, odd, two);
    for (int i = 0; i < ewl; i++) send_bit(d[i]);
    if (p_en) send_bit(pbit);
    send_bit(s1);
    if (two) send_bit(s2);
`ifdef RJ_PARITY_CHECK_EN
    e_perr = p_en && ((^md ^ pbit) != odd);
`else
    e_perr = 1'b0;
`endif
    if (expect_out) exp_q.push_back({md, e_perr, ~s1 | (two & ~s2)});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dout_valid) && n < 200) begin
      tick(); n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 0; bit_stb = 0; bit_in = 0; word_len = 4'd8;
    pen = 0; ohel = 0; two_stop = 0; dout_ready = 0; ovf_clr = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);

    // 8N1 0xA5 with latency: PUSH cycle then valid
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, 1);
    chk("lat_push_valid", 32'(dout_valid), 0);
    chk("lat_push_busy", 32'(busy), 1);
    tick();
    chk("lat_valid", 32'(dout_valid), 1);
    chk("lat_busy_fall", 32'(busy), 0);
    dout_ready = 1'b1;
    wait_drain();

    // 7E1 bad parity, 7O1 good parity, 5N2 bad second stop
    send_frame(8'h41, 7, 1, 0, 0, 1, 1, 1, 1);
    send_frame(8'h2A, 7, 1, 1, 0, 0, 1, 1, 1);
    send_frame(8'hF5, 5, 0, 0, 1, 0, 1, 0, 1);
    // out-of-range word lengths fall back to 8 bits
    send_frame(8'hC3, 15, 0, 0, 0, 0, 1, 1, 1);
    send_frame(8'h96, 3, 0, 0, 1, 0, 0, 1, 1);
    wait_drain();

    // overrun: third frame dropped while host stalls
    dout_ready = 1'b0;
    send_frame(8'h11, 8, 0, 0, 0, 0, 1, 1, 1);
    send_frame(8'h22, 8, 0, 0, 0, 0, 1, 1, 1);
    send_frame(8'h33, 8, 0, 0, 0, 0, 1, 1, 0);
    tick(); tick();
    chk("ovf_set", 32'(ovf), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    dout_ready = 1'b1;
    wait_drain();
    chk("valid_after_drain", 32'(dout_valid), 0);

    // abort after 3 bits, then full 0x3C frame; start with a coincident strobe
    frame_start(8, 0, 0, 0);
    send_bit(1); send_bit(0); send_bit(1);
    bit_stb = 1'b1; bit_in = 1'b1;
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_drain();

    // reset mid-frame with one buffered word
    dout_ready = 1'b0;
    send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 1, 0);
    tick();
    frame_start(8, 0, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_outs", {26'd0, dout_valid, busy, ovf, perr, ferr, |dout}, 0);
    dout_ready = 1'b1;
    send_frame(8'h7E, 8, 0, 0, 0, 0, 1, 1, 1);
    wait_drain();
    for (int i = 0; i < 5; i++) tick();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
